// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;

    typedef enum logic [0:0] {
        StReq,
        StWait
    } fetch_state_e;

    // One instruction-buffer entry: the fetched word and the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } ibuf_entry_t;

endpackage

// File: rtl/fetch_stage_inst_fifo.sv
// Instruction buffer: synchronous FIFO of {pc, word}. Flush beats push and pop.
module inst_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  ibuf_entry_t                wdata,
    output ibuf_entry_t                rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    ibuf_entry_t   mem_q [DEPTH];
    ibuf_entry_t   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a push into a full buffer is fine then.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next-state for pointers, occupancy and storage.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, one-outstanding-request fetch FSM, buffer and decode-facing register.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int unsigned IBUF_DEPTH = 2,
    parameter logic [31:0] NOP_WORD   = NOP_WORD_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_if,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_data,
    output logic [31:0] ir,
    output logic [31:0] pc_out,
    output logic        ir_valid
);
    localparam int unsigned CW = $clog2(IBUF_DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          drop_q, drop_d;
    logic [31:0]   ir_q, ir_d;
    logic [31:0]   pc_out_q, pc_out_d;
    logic          ir_valid_q, ir_valid_d;

    logic          buf_push, buf_pop, buf_flush, buf_full, buf_empty;
    logic [CW-1:0] buf_count;
    ibuf_entry_t   buf_wdata, buf_rdata;
    logic          in_flight, slot_free;

    assign in_flight = (state_q == StWait);
    assign slot_free = !buf_full && ((buf_count + CW'(in_flight)) < CW'(IBUF_DEPTH));

    // No request while reset or a redirect is pending: the old fetch_pc is about to be replaced.
    assign imem_req  = (state_q == StReq) && slot_free && !reset && !redirect_valid;
    assign imem_addr = fetch_pc_q;

    // fetch_pc already advanced past the in-flight word, so its address is one step back.
    assign buf_wdata = '{pc: fetch_pc_q - PC_STEP, word: imem_data};
    assign buf_flush = redirect_valid;

    assign ir       = ir_q;
    assign pc_out   = pc_out_q;
    assign ir_valid = ir_valid_q;

    inst_fifo #(
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clock (clock),
        .reset (reset),
        .push  (buf_push),
        .pop   (buf_pop),
        .flush (buf_flush),
        .wdata (buf_wdata),
        .rdata (buf_rdata),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count)
    );

    // Fetch FSM, PC advance and stale-response drop tracking.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        buf_push   = 1'b0;
        // Responses are in order, so the first one seen while drop is set is the stale one.
        if (drop_q && imem_valid) begin
            drop_d = 1'b0;
        end
        unique case (state_q)
            StReq: begin
                if (imem_req) begin
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                    state_d    = StWait;
                end
            end
            StWait: begin
                // With drop set, the request issued after the redirect is still outstanding.
                if (imem_valid && !drop_q) begin
                    buf_push = 1'b1;
                    state_d  = StReq;
                end
            end
        endcase
        if (redirect_valid) begin
            buf_push   = 1'b0;
            fetch_pc_d = redirect_pc;
            state_d    = StReq;
            // One bit tracks at most one stale response still to come back.
            drop_d     = (in_flight && drop_q) || ((in_flight || drop_q) && !imem_valid);
        end
    end

    // Decode-facing register: hold on stall, pop or bubble otherwise; redirect wins.
    always_comb begin
        ir_d       = ir_q;
        pc_out_d   = pc_out_q;
        ir_valid_d = ir_valid_q;
        buf_pop    = 1'b0;
        if (redirect_valid) begin
            ir_d       = NOP_WORD;
            ir_valid_d = 1'b0;
        end else if (!stall_if) begin
            if (!buf_empty) begin
                buf_pop    = 1'b1;
                ir_d       = buf_rdata.word;
                pc_out_d   = buf_rdata.pc;
                ir_valid_d = 1'b1;
            end else begin
                ir_d       = NOP_WORD;
                ir_valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StReq;
            fetch_pc_q <= RESET_PC;
            drop_q     <= 1'b0;
            ir_q       <= NOP_WORD;
            pc_out_q   <= 32'h0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
            ir_q       <= ir_d;
            pc_out_q   <= pc_out_d;
            ir_valid_q <= ir_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a variable-latency memory that returns the address as data.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset, stall_if, redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_valid;
    logic [31:0] imem_addr, imem_data;
    logic [31:0] ir, pc_out;
    logic        ir_valid;

    // Second instance with a reset PC just below the 32-bit wrap point.
    logic        w_req, w_valid, w_ir_valid;
    logic [31:0] w_addr, w_data, w_ir, w_pc_out;

    int n_checks = 0;
    int n_pass   = 0;

    int mem_auto = 1;
    int mem_lat  = 1;

    always #5 clock = ~clock;

    fetch_stage u_dut (
        .clock          (clock),
        .reset          (reset),
        .stall_if       (stall_if),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_data      (imem_data),
        .ir             (ir),
        .pc_out         (pc_out),
        .ir_valid       (ir_valid)
    );

    fetch_stage #(
        .RESET_PC (32'hFFFF_FFF8)
    ) u_dut_wrap (
        .clock          (clock),
        .reset          (reset),
        .stall_if       (stall_if),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_valid     (w_valid),
        .imem_data      (w_data),
        .ir             (w_ir),
        .pc_out         (w_pc_out),
        .ir_valid       (w_ir_valid)
    );

    // In-order memory for u_dut: a request seen at edge k is answered for sampling at edge k+mem_lat.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    initial begin
        mreq_t       mq[$];
        logic        req_s;
        logic [31:0] addr_s;
        int          cyc_n;
        cyc_n = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                mq.delete();
                req_s = 1'b0;
            end else begin
                req_s  = imem_req;
                addr_s = imem_addr;
            end
            addr_s = imem_addr;
            @(posedge clock);
            #1;
            cyc_n++;
            if (mem_auto != 0) begin
                if (req_s) mq.push_back('{addr: addr_s, due: cyc_n + mem_lat - 1});
                imem_valid = 1'b0;
                imem_data  = 32'h0;
                if (mq.size() > 0 && mq[0].due == cyc_n) begin
                    imem_valid = 1'b1;
                    imem_data  = mq[0].addr;
                    void'(mq.pop_front());
                end
            end
        end
    end

    // One-cycle memory for the wrap instance.
    initial begin
        logic        wreq_s;
        logic [31:0] waddr_s;
        w_valid = 1'b0;
        w_data  = 32'h0;
        forever begin
            @(negedge clock);
            wreq_s  = w_req && !reset;
            waddr_s = w_addr;
            @(posedge clock);
            #1;
            w_valid = wreq_s;
            w_data  = waddr_s;
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) cyc();
        n_checks++; if (ir !== 32'h0) $display("FAIL reset_ir: got %h want %h", ir, 32'h0); else n_pass++;
        n_checks++; if (pc_out !== 32'h0) $display("FAIL reset_pc_out: got %h want %h", pc_out, 32'h0); else n_pass++;
        n_checks++; if (ir_valid !== 1'b0) $display("FAIL reset_ir_valid: got %b want 0", ir_valid); else n_pass++;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_imem_req: got %b want 0", imem_req); else n_pass++;
        reset = 1'b0;
        #1;
    endtask

    // Words 0,4,8 from a 1-cycle memory; bubbles must read NOP. Leaves stall_if high with ir=8.
    task automatic test_fetch_seq();
        logic [31:0] exp_w;
        exp_w = 32'h0;
        n_checks++; if (imem_req !== 1'b1) $display("FAIL seq_first_req: got %b want 1", imem_req); else n_pass++;
        n_checks++; if (imem_addr !== 32'h0) $display("FAIL seq_first_addr: got %h want %h", imem_addr, 32'h0); else n_pass++;
        for (int i = 0; i < 40 && exp_w != 32'hC; i++) begin
            cyc();
            if (ir_valid === 1'b1) begin
                n_checks++; if (ir !== exp_w) $display("FAIL seq_ir: got %h want %h", ir, exp_w); else n_pass++;
                n_checks++; if (pc_out !== exp_w) $display("FAIL seq_pc_out: got %h want %h", pc_out, exp_w); else n_pass++;
                exp_w = exp_w + 32'd4;
            end else begin
                n_checks++; if (ir !== 32'h0) $display("FAIL seq_bubble_ir: got %h want %h", ir, 32'h0); else n_pass++;
            end
        end
        n_checks++; if (exp_w !== 32'hC) $display("FAIL seq_timeout: got next %h want %h", exp_w, 32'hC); else n_pass++;
        stall_if = 1'b1;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++; if (ir !== 32'h8) $display("FAIL stall_ir: got %h want %h", ir, 32'h8); else n_pass++;
            n_checks++; if (pc_out !== 32'h8) $display("FAIL stall_pc_out: got %h want %h", pc_out, 32'h8); else n_pass++;
            n_checks++; if (ir_valid !== 1'b1) $display("FAIL stall_ir_valid: got %b want 1", ir_valid); else n_pass++;
        end
        n_checks++; if (imem_req !== 1'b0) $display("FAIL stall_full_req: got %b want 0", imem_req); else n_pass++;
        stall_if = 1'b0;
        cyc();
        n_checks++; if (ir !== 32'hC) $display("FAIL release_ir0: got %h want %h", ir, 32'hC); else n_pass++;
        n_checks++; if (pc_out !== 32'hC) $display("FAIL release_pc0: got %h want %h", pc_out, 32'hC); else n_pass++;
        cyc();
        n_checks++; if (ir !== 32'h10) $display("FAIL release_ir1: got %h want %h", ir, 32'h10); else n_pass++;
        n_checks++; if (pc_out !== 32'h10) $display("FAIL release_pc1: got %h want %h", pc_out, 32'h10); else n_pass++;
        n_checks++; if (ir_valid !== 1'b1) $display("FAIL release_valid1: got %b want 1", ir_valid); else n_pass++;
    endtask

    // Redirect while a 3-cycle response is in flight: the late word must never reach ir.
    task automatic test_redirect_wait();
        logic found;
        found   = 1'b0;
        mem_lat = 3;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            if (imem_req === 1'b1) found = 1'b1;
        end
        n_checks++; if (found !== 1'b1) $display("FAIL rdw_req_timeout: got %b want 1", found); else n_pass++;
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cyc();
        redirect_valid = 1'b0;
        #1;
        n_checks++; if (ir_valid !== 1'b0) $display("FAIL rdw_bubble_valid: got %b want 0", ir_valid); else n_pass++;
        n_checks++; if (ir !== 32'h0) $display("FAIL rdw_bubble_ir: got %h want %h", ir, 32'h0); else n_pass++;
        n_checks++; if (imem_req !== 1'b1) $display("FAIL rdw_req: got %b want 1", imem_req); else n_pass++;
        n_checks++; if (imem_addr !== 32'h100) $display("FAIL rdw_addr: got %h want %h", imem_addr, 32'h100); else n_pass++;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cyc();
            if (ir_valid === 1'b1) found = 1'b1;
        end
        n_checks++; if (pc_out !== 32'h100) $display("FAIL rdw_first_pc: got %h want %h", pc_out, 32'h100); else n_pass++;
        n_checks++; if (ir !== 32'h100) $display("FAIL rdw_first_ir: got %h want %h", ir, 32'h100); else n_pass++;
    endtask

    task automatic test_redirect_stall();
        logic found;
        mem_lat        = 1;
        stall_if       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        cyc();
        stall_if       = 1'b0;
        redirect_valid = 1'b0;
        #1;
        n_checks++; if (ir_valid !== 1'b0) $display("FAIL rds_valid: got %b want 0", ir_valid); else n_pass++;
        n_checks++; if (ir !== 32'h0) $display("FAIL rds_ir: got %h want %h", ir, 32'h0); else n_pass++;
        n_checks++; if (imem_addr !== 32'h200) $display("FAIL rds_addr: got %h want %h", imem_addr, 32'h200); else n_pass++;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cyc();
            if (ir_valid === 1'b1) found = 1'b1;
        end
        n_checks++; if (pc_out !== 32'h200) $display("FAIL rds_first_pc: got %h want %h", pc_out, 32'h200); else n_pass++;
        n_checks++; if (ir !== 32'h200) $display("FAIL rds_first_ir: got %h want %h", ir, 32'h200); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        int          k;
        exp_pc[0] = 32'hFFFF_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000;
        k     = 0;
        reset = 1'b1;
        repeat (2) cyc();
        n_checks++; if (w_pc_out !== 32'h0) $display("FAIL wrap_reset_pc: got %h want %h", w_pc_out, 32'h0); else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++; if (w_addr !== 32'hFFFF_FFF8) $display("FAIL wrap_first_addr: got %h want %h", w_addr, 32'hFFFF_FFF8); else n_pass++;
        for (int i = 0; i < 40 && k < 3; i++) begin
            cyc();
            if (w_ir_valid === 1'b1) begin
                n_checks++; if (w_pc_out !== exp_pc[k]) $display("FAIL wrap_pc: got %h want %h", w_pc_out, exp_pc[k]); else n_pass++;
                n_checks++; if (w_ir !== exp_pc[k]) $display("FAIL wrap_ir: got %h want %h", w_ir, exp_pc[k]); else n_pass++;
                k++;
            end
        end
        n_checks++; if (k != 3) $display("FAIL wrap_timeout: got %0d words want 3", k); else n_pass++;
    endtask

    // Reset lands while a request is outstanding; responses around it must be ignored.
    task automatic test_reset_in_wait();
        reset      = 1'b1;
        mem_auto   = 0;
        imem_valid = 1'b0;
        imem_data  = 32'h0;
        repeat (2) cyc();
        reset = 1'b0;
        cyc();
        reset      = 1'b1;
        imem_valid = 1'b1;
        imem_data  = 32'hDEAD_BEEF;
        cyc();
        reset = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1) $display("FAIL riw_req: got %b want 1", imem_req); else n_pass++;
        n_checks++; if (imem_addr !== 32'h0) $display("FAIL riw_addr: got %h want %h", imem_addr, 32'h0); else n_pass++;
        n_checks++; if (ir_valid !== 1'b0) $display("FAIL riw_valid0: got %b want 0", ir_valid); else n_pass++;
        cyc();
        imem_data = 32'h0000_0055;
        n_checks++; if (ir_valid !== 1'b0) $display("FAIL riw_valid1: got %b want 0", ir_valid); else n_pass++;
        cyc();
        imem_valid = 1'b0;
        n_checks++; if (ir_valid !== 1'b0) $display("FAIL riw_valid2: got %b want 0", ir_valid); else n_pass++;
        cyc();
        n_checks++; if (ir !== 32'h55) $display("FAIL riw_ir: got %h want %h", ir, 32'h55); else n_pass++;
        n_checks++; if (pc_out !== 32'h0) $display("FAIL riw_pc_out: got %h want %h", pc_out, 32'h0); else n_pass++;
        n_checks++; if (ir_valid !== 1'b1) $display("FAIL riw_valid3: got %b want 1", ir_valid); else n_pass++;
    endtask

    initial begin
        reset          = 1'b1;
        stall_if       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_valid     = 1'b0;
        imem_data      = 32'h0;
        test_reset();
        test_fetch_seq();
        test_stall();
        test_redirect_wait();
        test_redirect_stall();
        test_wrap();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish by 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
